fruit_drop_move: RTL and testbench
==================================

// Module: fruit_drop_move
// PURPOSE
// - Controls the vertical trajectory of a droppable fruit.
// - Fruit hangs still until dropRequest (player touches fruit), then falls under gravity.
//   Ends on enemy collision (score event) or floor landing (miss event), then respawns.
// - Command-driven counterpart of the autonomous oscillating movers. Sits between the collision
//   unit and the fruit bitmap/draw block, which consumes topLeftX/topLeftY/visible.
// PARAMETERS
// - INITIAL_X           default 320  fixed X of the fruit, pixels
// - INITIAL_Y           default 226  hanging Y position, pixels
// - FLOOR_Y             default 544  Y at which a falling fruit lands, pixels
// - INITIAL_DROP_SPEED  default 64   Yspeed loaded on drop, fixed-point units per frame
// - GRAVITY             default 8    Yspeed increment per frame while falling, fixed-point units
// - MAX_Y_SPEED         default 256  Yspeed saturation value, fixed-point units
// - RESPAWN_FRAMES      default 30   frames spent invisible before re-hanging; 0 is treated as 1
// PORTS
// - clk            in   1       system clock
// - resetN         in   1       asynchronous active-low reset
// - startOfFrame   in   1       one-cycle pulse per video frame
// - dropRequest    in   1       pulse: player collided with the hanging fruit
// - enemyCollision in   1       pulse/level: falling fruit overlaps an enemy
// - topLeftX       out  11 s    fixed, = INITIAL_X
// - topLeftY       out  11 s    current Y, pixels
// - visible        out  1       fruit must be drawn / is collidable
// - enemyHit       out  1       one-cycle pulse: fruit hit an enemy
// - landed         out  1       one-cycle pulse: fruit reached the floor
// BEHAVIOUR
// - Fixed point: position and speed are in 1/128 pixel (multiplier 128, int width).
//   topLeftY = Y_fp / 128, truncated; Y_fp is never negative.
// - Reset (async, any state):
//   - state=HANGING, Y_fp=INITIAL_Y*128, Yspeed=0, frameCnt=0.
//   - visible=1, enemyHit=0, landed=0.
// - HANGING:
//   - visible=1, Y frozen.
//   - dropRequest=1 -> FALLING, Yspeed<=INITIAL_DROP_SPEED. Takes effect even if startOfFrame
//     is high in the same cycle; no position update that cycle.
//   - enemyCollision is ignored.
// - FALLING, per startOfFrame:
//   - Y_fp <= Y_fp + Yspeed (old speed).
//   - Yspeed <= min(Yspeed+GRAVITY, MAX_Y_SPEED).
// - FALLING, landing: if Y_fp + Yspeed >= FLOOR_Y*128 on that frame:
//   - Y_fp clamped to FLOOR_Y*128.
//   - landed=1 for the next cycle.
//   - -> WAIT, frameCnt<=0.
// - FALLING, enemy: enemyCollision=1 in any cycle:
//   - -> WAIT, enemyHit=1 for one cycle, Y frozen.
//   - Enemy takes priority over landing and over the position update in the same cycle.
//   - A held level produces only one pulse.
// - dropRequest is ignored outside HANGING.
// - WAIT:
//   - visible=0; enemyCollision and dropRequest are ignored.
//   - Each startOfFrame increments frameCnt.
//   - On the RESPAWN_FRAMES-th pulse -> HANGING, Y_fp<=INITIAL_Y*128, Yspeed<=0, visible=1
//     next cycle.
// - Output timing: all outputs are registered; a state change is visible one cycle after the
//   causing input. enemyHit and landed are never both 1.
// TESTING
// - Reset -> topLeftY=226, topLeftX=320, visible=1. 100 frames with no drop -> Y stays 226.
// - Drop, then 3 frames -> Y_fp = 28928+64+72+80 = 29144, topLeftY=227.
//   Yspeed reaches 256 after 24 frames and stays 256.
// - Keep falling -> topLeftY==544 exactly, one landed pulse, visible=0.
//   Exactly 30 frames later: visible=1, topLeftY=226.
// - enemyCollision during FALLING at Y≈300 -> one enemyHit pulse, Y frozen, visible=0.
//   Collision held for 5 cycles -> still a single pulse.
// - enemyCollision and the landing frame in the same cycle -> enemyHit only, no landed, Y not
//   updated.
// - resetN low mid-FALL or mid-WAIT -> immediate HANGING at 226.
//   dropRequest while in WAIT -> ignored.
//   dropRequest with startOfFrame in the same cycle -> Y unchanged until the next frame.

Source files
------------

// File: rtl/fruit_drop_move_if.sv
// Fruit mover bus: frame/collision commands in, fruit position and events out.
// master = collision/frame side, slave = the mover itself.
interface fruit_drop_move_if;
    logic               startOfFrame;
    logic               dropRequest;
    logic               enemyCollision;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               visible;
    logic               enemyHit;
    logic               landed;

    modport master (
        output startOfFrame,
        output dropRequest,
        output enemyCollision,
        input  topLeftX,
        input  topLeftY,
        input  visible,
        input  enemyHit,
        input  landed
    );

    modport slave (
        input  startOfFrame,
        input  dropRequest,
        input  enemyCollision,
        output topLeftX,
        output topLeftY,
        output visible,
        output enemyHit,
        output landed
    );
endinterface

// File: rtl/fruit_drop_move.sv
// Droppable fruit: hangs until touched, falls under gravity, ends on enemy or
// floor, then respawns after a fixed number of frames.
module fruit_drop_move #(
    parameter int INITIAL_X          = 320,
    parameter int INITIAL_Y          = 226,
    parameter int FLOOR_Y            = 544,
    parameter int INITIAL_DROP_SPEED = 64,
    parameter int GRAVITY            = 8,
    parameter int MAX_Y_SPEED        = 256,
    parameter int RESPAWN_FRAMES     = 30
) (
    input logic              clk,
    input logic              resetN,
    fruit_drop_move_if.slave bus
);

    localparam int FP = 128;
    localparam logic [31:0] INIT_FP  = 32'(INITIAL_Y * FP);
    localparam logic [31:0] FLOOR_FP = 32'(FLOOR_Y * FP);
    localparam logic [31:0] DROP_SPD = 32'(INITIAL_DROP_SPEED);
    localparam logic [31:0] GRAV     = 32'(GRAVITY);
    localparam logic [31:0] MAX_SPD  = 32'(MAX_Y_SPEED);
    localparam logic [31:0] RESP     =
        (RESPAWN_FRAMES < 1) ? 32'd1 : 32'(RESPAWN_FRAMES);

    typedef enum logic [1:0] {
        HANGING,
        FALLING,
        WAIT
    } state_t;

    state_t      state;
    logic [31:0] y_fp;
    logic [31:0] speed;
    logic [31:0] frame_cnt;
    logic        visible_q;
    logic        hit_q;
    logic        land_q;

    logic [31:0] y_next;
    logic [31:0] spd_sum;
    logic [31:0] spd_next;
    logic [31:0] cnt_next;

    assign y_next   = y_fp + speed;
    assign spd_sum  = speed + GRAV;
    assign spd_next = (spd_sum > MAX_SPD) ? MAX_SPD : spd_sum;
    assign cnt_next = frame_cnt + 32'd1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= HANGING;
            y_fp      <= INIT_FP;
            speed     <= '0;
            frame_cnt <= '0;
            visible_q <= 1'b1;
            hit_q     <= 1'b0;
            land_q    <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            land_q <= 1'b0;
            unique case (state)
                HANGING: begin
                    if (bus.dropRequest) begin
                        state <= FALLING;
                        speed <= DROP_SPD;
                    end
                end
                FALLING: begin
                    // enemy wins over both landing and the frame update
                    if (bus.enemyCollision) begin
                        state     <= WAIT;
                        hit_q     <= 1'b1;
                        visible_q <= 1'b0;
                        frame_cnt <= '0;
                    end else if (bus.startOfFrame) begin
                        if (y_next >= FLOOR_FP) begin
                            state     <= WAIT;
                            y_fp      <= FLOOR_FP;
                            land_q    <= 1'b1;
                            visible_q <= 1'b0;
                            frame_cnt <= '0;
                        end else begin
                            y_fp  <= y_next;
                            speed <= spd_next;
                        end
                    end
                end
                WAIT: begin
                    if (bus.startOfFrame) begin
                        if (cnt_next >= RESP) begin
                            state     <= HANGING;
                            y_fp      <= INIT_FP;
                            speed     <= '0;
                            frame_cnt <= '0;
                            visible_q <= 1'b1;
                        end else begin
                            frame_cnt <= cnt_next;
                        end
                    end
                end
                default: begin
                    state <= HANGING;
                end
            endcase
        end
    end

    assign bus.topLeftX = 11'(INITIAL_X);
    assign bus.topLeftY = 11'(y_fp >> 7);
    assign bus.visible  = visible_q;
    assign bus.enemyHit = hit_q;
    assign bus.landed   = land_q;

endmodule

// File: tb/tb_fruit_drop_move.sv
// Bench for fruit_drop_move: trajectory model from closed-form fall sums,
// checked every cycle, plus literal pins on key positions and pulses.
module tb_fruit_drop_move;

    localparam int IX = 320;
    localparam int IY = 226;
    localparam int FLOOR = 544;
    localparam int RESP = 30;

    logic clk = 1'b0;
    logic resetN = 1'b0;

    fruit_drop_move_if bus ();

    fruit_drop_move dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model: 0 hanging, 1 falling, 2 waiting
    int m_phase;
    int m_n;
    int m_w;
    int m_yw;
    int m_hit;
    int m_land;

    int hits = 0;
    int lands = 0;

    // Y_fp after n frames of fall: start plus the sum of the capped speeds
    function automatic int ypos(input int n);
        int s;
        int v;
        s = IY * 128;
        for (int k = 0; k < n; k++) begin
            v = 64 + 8 * k;
            s += (v > 256) ? 256 : v;
        end
        return s;
    endfunction

    function automatic int exp_y();
        if (m_phase == 1) return ypos(m_n) / 128;
        if (m_phase == 2) return m_yw / 128;
        return IY;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase <= 0;
            m_n     <= 0;
            m_w     <= 0;
            m_yw    <= 0;
            m_hit   <= 0;
            m_land  <= 0;
        end else begin
            m_hit  <= 0;
            m_land <= 0;
            if (m_phase == 0) begin
                if (bus.dropRequest) begin
                    m_phase <= 1;
                    m_n     <= 0;
                end
            end else if (m_phase == 1) begin
                if (bus.enemyCollision) begin
                    m_phase <= 2;
                    m_yw    <= ypos(m_n);
                    m_w     <= 0;
                    m_hit   <= 1;
                end else if (bus.startOfFrame) begin
                    if (ypos(m_n + 1) >= FLOOR * 128) begin
                        m_phase <= 2;
                        m_yw    <= FLOOR * 128;
                        m_w     <= 0;
                        m_land  <= 1;
                    end else begin
                        m_n <= m_n + 1;
                    end
                end
            end else begin
                if (bus.startOfFrame) begin
                    if (m_w + 1 >= RESP) m_phase <= 0;
                    else m_w <= m_w + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endtask

    // one cycle: let the edge pass, then compare everything at the negedge
    task automatic tick();
        @(negedge clk);
        if (bus.enemyHit) hits++;
        if (bus.landed) lands++;
        chk("x", int'(bus.topLeftX), IX);
        chk("y", int'(bus.topLeftY), exp_y());
        chk("visible", int'(bus.visible), (m_phase != 2) ? 1 : 0);
        chk("enemyHit", int'(bus.enemyHit), m_hit);
        chk("landed", int'(bus.landed), m_land);
        chk("exclusive", int'(bus.enemyHit & bus.landed), 0);
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic drop();
        bus.dropRequest = 1'b1;
        tick();
        bus.dropRequest = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("rst_y", int'(bus.topLeftY), IY);
        chk("rst_vis", int'(bus.visible), 1);
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic fall_until_land();
        int guard;
        guard = 0;
        while (m_phase == 1 && guard < 400) begin
            frame();
            guard++;
        end
        chk("land_timeout", (guard < 400) ? 1 : 0, 1);
    endtask

    int h0;
    int l0;
    int yk;
    int guard;

    initial begin
        bus.startOfFrame   = 1'b0;
        bus.dropRequest    = 1'b0;
        bus.enemyCollision = 1'b0;

        chk("model_y3", ypos(3), 29144);
        chk("model_spd24", ypos(25) - ypos(24), 256);
        chk("model_spd30", ypos(31) - ypos(30), 256);

        do_reset();
        chk("init_y", int'(bus.topLeftY), 226);
        chk("init_x", int'(bus.topLeftX), 320);
        chk("init_vis", int'(bus.visible), 1);
        for (int i = 0; i < 100; i++) frame();
        chk("hang_y", int'(bus.topLeftY), 226);

        // enemy while hanging is ignored
        bus.enemyCollision = 1'b1;
        tick();
        tick();
        bus.enemyCollision = 1'b0;
        tick();
        chk("hang_enemy_vis", int'(bus.visible), 1);

        drop();
        for (int i = 0; i < 3; i++) frame();
        chk("fall3_y", int'(bus.topLeftY), 227);

        l0 = lands;
        fall_until_land();
        chk("land_y", int'(bus.topLeftY), 544);
        chk("land_cnt", lands - l0, 1);
        chk("land_vis", int'(bus.visible), 0);
        drop();
        for (int i = 0; i < 29; i++) frame();
        chk("wait29_vis", int'(bus.visible), 0);
        frame();
        chk("respawn_vis", int'(bus.visible), 1);
        chk("respawn_y", int'(bus.topLeftY), 226);

        // enemy at ~300, held 5 cycles
        drop();
        guard = 0;
        while (int'(bus.topLeftY) < 300 && guard < 200) begin
            frame();
            guard++;
        end
        chk("reach300", (guard < 200) ? 1 : 0, 1);
        yk = int'(bus.topLeftY);
        h0 = hits;
        bus.enemyCollision = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.enemyCollision = 1'b0;
        frame();
        chk("hit_cnt", hits - h0, 1);
        chk("hit_y", int'(bus.topLeftY), yk);
        chk("hit_vis", int'(bus.visible), 0);
        for (int i = 0; i < 30; i++) frame();
        chk("respawn2_vis", int'(bus.visible), 1);

        // enemy on the landing frame
        drop();
        guard = 0;
        while (ypos(m_n + 1) < FLOOR * 128 && guard < 400) begin
            frame();
            guard++;
        end
        yk = int'(bus.topLeftY);
        h0 = hits;
        l0 = lands;
        bus.enemyCollision = 1'b1;
        bus.startOfFrame = 1'b1;
        tick();
        bus.enemyCollision = 1'b0;
        bus.startOfFrame = 1'b0;
        tick();
        chk("tie_hit", hits - h0, 1);
        chk("tie_land", lands - l0, 0);
        chk("tie_y", int'(bus.topLeftY), yk);

        // reset mid-WAIT
        for (int i = 0; i < 5; i++) frame();
        do_reset();
        chk("rst_wait_vis", int'(bus.visible), 1);

        // reset mid-FALL
        drop();
        for (int i = 0; i < 20; i++) frame();
        do_reset();
        chk("rst_fall_y", int'(bus.topLeftY), 226);

        // drop together with a frame pulse: no move that cycle
        bus.dropRequest = 1'b1;
        bus.startOfFrame = 1'b1;
        tick();
        bus.dropRequest = 1'b0;
        bus.startOfFrame = 1'b0;
        tick();
        chk("dropsof_y", int'(bus.topLeftY), 226);
        frame();
        frame();
        chk("dropsof_y2", int'(bus.topLeftY), 227);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
